// File: rtl/mem_image_loader.sv
// Streams a program image into a word-addressed memory after zero-filling it,
// holding the processor in reset until a complete image has been written.
module mem_image_loader #(
    parameter int          D_SIZE  = 32,
    parameter int          DEPTH   = 1024,
    parameter logic [5:0]  HALT_OP = 6'b010001,
    localparam int         AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [D_SIZE-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [D_SIZE-1:0] mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              halt_seen,
    output logic [AW:0]       word_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};

    function automatic logic is_halt(input logic [D_SIZE-1:0] word);
        return (word[31:26] == HALT_OP);
    endfunction

    state_e              state_q, state_d;
    logic [AW-1:0]       clr_ptr_q, clr_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]         word_cnt_q, word_cnt_d;
    logic                halt_seen_q, halt_seen_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [D_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept_s;

    assign s_ready  = (state_q == LOAD);
    assign accept_s = s_valid && s_ready;

    // Next-state, pointer and registered-output decode
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        word_cnt_d  = word_cnt_q;
        halt_seen_d = halt_seen_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d     = CLEAR;
                    clr_ptr_d   = PTR_ZERO;
                    wr_ptr_d    = PTR_ZERO;
                    word_cnt_d  = CNT_ZERO;
                    halt_seen_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            CLEAR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_ptr_q;
                mem_wdata_d = {D_SIZE{1'b0}};
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d  = LOAD;
                    wr_ptr_d = PTR_ZERO;
                end else begin
                    clr_ptr_d = clr_ptr_q + PTR_ONE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q;
                    mem_wdata_d = s_data;
                    word_cnt_d  = word_cnt_q + CNT_ONE;
                    halt_seen_d = halt_seen_q | is_halt(s_data);
                    // The pointer never wraps: a full memory either completes or errors.
                    if (s_last) begin
                        state_d = DONE;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        state_d = ERR;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d       = (state_d == CLEAR) || (state_d == LOAD);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
        core_rst_n_d = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            clr_ptr_q    <= PTR_ZERO;
            wr_ptr_q     <= PTR_ZERO;
            word_cnt_q   <= CNT_ZERO;
            halt_seen_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= PTR_ZERO;
            mem_wdata_q  <= {D_SIZE{1'b0}};
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            word_cnt_q   <= word_cnt_d;
            halt_seen_q  <= halt_seen_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign halt_seen  = halt_seen_q;
    assign word_cnt   = word_cnt_q;

endmodule
